// File: rtl/reg_file_scoreboard_pkg.sv
// Shared defaults and helpers for the 1W/2R register file with busy scoreboard.
package reg_file_scoreboard_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned REG_ZERO   = 0;

    // True when addr selects the hardwired-zero register and that feature is on.
    function automatic bit is_zero_reg(input int unsigned addr, input bit zero_r0);
        return zero_r0 && (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bus of the register file: stall, write, two reads, issue, busy.
interface reg_file_scoreboard_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic              en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              a_busy;
    logic              b_busy;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output en, wr_en, wr_addr, wr_data, a_addr, b_addr, issue_en, issue_addr,
        input  a_data, b_data, a_busy, b_busy, busy_vec
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, a_addr, b_addr, issue_en, issue_addr,
        output a_data, b_data, a_busy, b_busy, busy_vec
    );

endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Per-register busy bits: write clears, issue sets (issue wins on same address).
module rf_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_wr_en,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic                 i_issue_en,
    input  logic [ADDR_W-1:0]    i_issue_addr,
    output logic [2**ADDR_W-1:0] o_busy,
    output logic [2**ADDR_W-1:0] o_busy_next
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    always_comb begin
        w_busy_next = r_busy;
        if (i_wr_en)
            w_busy_next[i_wr_addr] = 1'b0;
        if (i_issue_en)
            w_busy_next[i_issue_addr] = 1'b1;
        if (ZERO_R0)
            w_busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else if (i_en)
            r_busy <= w_busy_next;
    end

    assign o_busy      = r_busy;
    assign o_busy_next = w_busy_next;

endmodule

// File: rtl/reg_file_scoreboard.sv
// 1-write/2-read register file with write-to-read bypass, optional zero R0, stall and busy scoreboard.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_a_data;
    logic [DATA_W-1:0] r_b_data;
    logic              r_a_busy;
    logic              r_b_busy;

    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_busy_next;
    logic              w_wr_do;
    logic [DATA_W-1:0] w_a_rd;
    logic [DATA_W-1:0] w_b_rd;

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk          (clk),
        .rst          (rst),
        .i_en         (bus.en),
        .i_wr_en      (bus.wr_en),
        .i_wr_addr    (bus.wr_addr),
        .i_issue_en   (bus.issue_en),
        .i_issue_addr (bus.issue_addr),
        .o_busy       (w_busy),
        .o_busy_next  (w_busy_next)
    );

    assign w_wr_do = bus.wr_en && !is_zero_reg(32'(bus.wr_addr), ZERO_R0);

    // Zero-register override is applied last so it beats the bypass path.
    always_comb begin
        w_a_rd = r_regs[bus.a_addr];
        w_b_rd = r_regs[bus.b_addr];
        if (BYPASS && w_wr_do && (bus.wr_addr == bus.a_addr))
            w_a_rd = bus.wr_data;
        if (BYPASS && w_wr_do && (bus.wr_addr == bus.b_addr))
            w_b_rd = bus.wr_data;
        if (is_zero_reg(32'(bus.a_addr), ZERO_R0))
            w_a_rd = '0;
        if (is_zero_reg(32'(bus.b_addr), ZERO_R0))
            w_b_rd = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_a_data <= '0;
            r_b_data <= '0;
            r_a_busy <= 1'b0;
            r_b_busy <= 1'b0;
        end else if (bus.en) begin
            if (w_wr_do)
                r_regs[bus.wr_addr] <= bus.wr_data;
            r_a_data <= w_a_rd;
            r_b_data <= w_b_rd;
            r_a_busy <= w_busy_next[bus.a_addr];
            r_b_busy <= w_busy_next[bus.b_addr];
        end
    end

    assign bus.a_data   = r_a_data;
    assign bus.b_data   = r_b_data;
    assign bus.a_busy   = r_a_busy;
    assign bus.b_busy   = r_b_busy;
    assign bus.busy_vec = w_busy;

endmodule
